// File: rtl/aurora_hls_nfc_ctrl.sv
// Aurora 64B/66B native flow control request generator: turns RX FIFO
// watermark flags into XOFF/XON words on the core's AXI4-Stream NFC input.
module aurora_hls_nfc_ctrl #(
    parameter logic [15:0] XOFF_CODE = 16'hFFFF,
    parameter logic [15:0] XON_CODE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_rx_prog_full,
    input  logic        fifo_rx_prog_empty,
    input  logic        s_axi_nfc_tready,
    output logic        s_axi_nfc_tvalid,
    output logic [15:0] s_axi_nfc_tdata
);

    // NFC handshake: a word transfers on a rising edge where tvalid and tready
    // are both 1; once tvalid is raised, tdata is frozen until that transfer.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SEND_XOFF = 2'd1,
        PAUSED    = 2'd2,
        SEND_XON  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        tvalid_q, tvalid_d;
    logic [15:0] tdata_q, tdata_d;
    logic        handshake;

    assign handshake = tvalid_q & s_axi_nfc_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            tvalid_q <= 1'b0;
            tdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    // Each state looks only at its own trigger; the gap between the two
    // watermarks gives the hysteresis, so PAUSED ignores prog_full dropping.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        unique case (state_q)
            RUN: begin
                if (fifo_rx_prog_full) begin
                    state_d  = SEND_XOFF;
                    tvalid_d = 1'b1;
                    tdata_d  = XOFF_CODE;
                end
            end
            SEND_XOFF: begin
                if (handshake) begin
                    state_d  = PAUSED;
                    tvalid_d = 1'b0;
                end
            end
            PAUSED: begin
                if (fifo_rx_prog_empty) begin
                    state_d  = SEND_XON;
                    tvalid_d = 1'b1;
                    tdata_d  = XON_CODE;
                end
            end
            SEND_XON: begin
                if (handshake) begin
                    state_d  = RUN;
                    tvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = RUN;
                tvalid_d = 1'b0;
            end
        endcase
    end

    assign s_axi_nfc_tvalid = tvalid_q;
    assign s_axi_nfc_tdata  = tdata_q;

endmodule

// File: tb/tb_aurora_hls_nfc_ctrl.sv
// Directed bench for aurora_hls_nfc_ctrl: XOFF/XON sequencing, backpressure,
// hysteresis and asynchronous reset behaviour.
module tb_aurora_hls_nfc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fifo_rx_prog_full;
    logic        fifo_rx_prog_empty;
    logic        s_axi_nfc_tready;
    logic        s_axi_nfc_tvalid;
    logic [15:0] s_axi_nfc_tdata;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int pulse_cnt;

    localparam logic [15:0] XOFF = 16'hFFFF;
    localparam logic [15:0] XON  = 16'h0000;

    aurora_hls_nfc_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fifo_rx_prog_full  (fifo_rx_prog_full),
        .fifo_rx_prog_empty (fifo_rx_prog_empty),
        .s_axi_nfc_tready   (s_axi_nfc_tready),
        .s_axi_nfc_tvalid   (s_axi_nfc_tvalid),
        .s_axi_nfc_tdata    (s_axi_nfc_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exp_v, input logic [15:0] exp_d);
        check({tag, "_tvalid"}, {15'd0, s_axi_nfc_tvalid}, {15'd0, exp_v});
        check({tag, "_tdata"}, s_axi_nfc_tdata, exp_d);
    endtask

    initial begin
        rst_n              = 1'b0;
        fifo_rx_prog_full  = 1'b0;
        fifo_rx_prog_empty = 1'b0;
        s_axi_nfc_tready   = 1'b0;

        // Reset for two cycles, then idle flags
        tick();
        tick();
        check_out("reset", 1'b0, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("idle_after_reset", 1'b0, 16'h0000);
        end

        // XOFF under backpressure: 1-cycle latency, then stable
        fifo_rx_prog_full = 1'b1;
        tick();
        check_out("xoff_latency", 1'b1, XOFF);
        for (int i = 0; i < 4; i++) tick();
        check_out("xoff_held", 1'b1, XOFF);

        // Accept: exactly one tvalid cycle in a 20-cycle window
        s_axi_nfc_tready = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_nfc_tvalid) pulse_cnt++;
            tick();
        end
        check("xoff_single_pulse", pulse_cnt[15:0], 16'd1);
        check_out("paused_full_high", 1'b0, XOFF);

        // prog_full drop alone stays paused
        fifo_rx_prog_full = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_out("paused_full_low", 1'b0, XOFF);

        // prog_empty triggers XON, accepted in one cycle
        fifo_rx_prog_empty = 1'b1;
        tick();
        check_out("xon_issue", 1'b1, XON);
        fifo_rx_prog_empty = 1'b0;
        tick();
        check_out("xon_accepted", 1'b0, XON);
        tick();
        check_out("run_idle", 1'b0, XON);

        // Back to PAUSED for the hysteresis check
        fifo_rx_prog_full = 1'b1;
        tick();
        check_out("xoff2_issue", 1'b1, XOFF);
        tick();
        check_out("xoff2_accepted", 1'b0, XOFF);
        fifo_rx_prog_full = 1'b0;
        tick();
        check_out("hyst_full0", 1'b0, XOFF);
        fifo_rx_prog_full = 1'b1;
        tick();
        check_out("hyst_full1", 1'b0, XOFF);
        fifo_rx_prog_full = 1'b0;
        tick();
        check_out("hyst_full0b", 1'b0, XOFF);

        // Stable hold in SEND_XON under backpressure with prog_full set
        s_axi_nfc_tready   = 1'b0;
        fifo_rx_prog_full  = 1'b1;
        fifo_rx_prog_empty = 1'b1;
        tick();
        check_out("xon_hold_start", 1'b1, XON);
        fifo_rx_prog_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("xon_hold", 1'b1, XON);
        end
        s_axi_nfc_tready = 1'b1;
        tick();
        check_out("xon_hold_accept", 1'b0, XON);
        s_axi_nfc_tready = 1'b0;
        tick();
        check_out("xoff_after_xon", 1'b1, XOFF);

        // Asynchronous reset mid-transfer, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 16'h0000);
        tick();
        check_out("reset_hold_full", 1'b0, 16'h0000);
        fifo_rx_prog_full = 1'b0;
        rst_n = 1'b1;
        tick();
        check_out("after_reset_run", 1'b0, 16'h0000);

        // Both flags high: RUN issues XOFF, PAUSED issues XON
        fifo_rx_prog_full  = 1'b1;
        fifo_rx_prog_empty = 1'b1;
        s_axi_nfc_tready   = 1'b1;
        tick();
        check_out("both_xoff", 1'b1, XOFF);
        tick();
        check_out("both_accept", 1'b0, XOFF);
        tick();
        check_out("both_xon", 1'b1, XON);
        tick();
        check_out("both_xon_accept", 1'b0, XON);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
